// File: rtl/mem_req_master_pkg.sv
// Shared types and helpers for the data-memory request master.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEF_MEMSIZE   = 64;
  localparam int unsigned RESERVED_WORD = DEF_MEMSIZE - 1;

  // Number of low address bits that select a byte within one data word.
  function automatic int unsigned byte_off_w(input int unsigned bitsize);
    return $clog2(bitsize / 8);
  endfunction

  function automatic int unsigned reserved_word(input int unsigned memsize);
    return memsize - 1;
  endfunction

endpackage

// File: rtl/mem_req_master_if.sv
// Request/response handshake and data-memory pins of the request master.
interface mem_req_master_if #(
  parameter int unsigned BITSIZE = 64,
  parameter int unsigned MEMSIZE = 64
);
  localparam int unsigned AW = $clog2(MEMSIZE);

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [BITSIZE-1:0] req_addr;
  logic [BITSIZE-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BITSIZE-1:0] rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      mem_addr;
  logic [BITSIZE-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [BITSIZE-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport mem (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/mem_req_master_addr_check.sv
// Byte address to word index conversion with reserved/out-of-range error flag.
// Build option: MEM_REQ_MISALIGN_TRAP_EN also flags addresses not aligned to a word.
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int unsigned BITSIZE = 64,
  parameter int unsigned MEMSIZE = 64
) (
  input  logic [BITSIZE-1:0]         addr,
  output logic [$clog2(MEMSIZE)-1:0] word,
  output logic                       err
);
  localparam int unsigned        AW  = $clog2(MEMSIZE);
  localparam int unsigned        OFF = byte_off_w(BITSIZE);
  localparam logic [BITSIZE-1:0] RSV = BITSIZE'(reserved_word(MEMSIZE));
`ifdef MEM_REQ_MISALIGN_TRAP_EN
  localparam logic [BITSIZE-1:0] LO_MASK = (BITSIZE'(1) << OFF) - BITSIZE'(1);
`endif

  logic [BITSIZE-1:0] w_full;

  always_comb begin
    w_full = addr >> OFF;
    word   = w_full[AW-1:0];
    // Compare the full-width index so addresses beyond the array also trap.
    err    = (w_full >= RSV);
`ifdef MEM_REQ_MISALIGN_TRAP_EN
    err    = err | ((addr & LO_MASK) != '0);
`endif
  end

endmodule

// File: rtl/mem_req_master.sv
// Initiator side of the data-memory interface: load/store requests in, memory pins out.
// Build option: MEM_REQ_MISALIGN_TRAP_EN (see mem_addr_check).
module mem_req_master
  import mem_pkg::*;
#(
  parameter int unsigned BITSIZE = 64,
  parameter int unsigned MEMSIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  mem_req_master_if.slave bus
);
  localparam int unsigned AW = $clog2(MEMSIZE);

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic               write_q;
  logic [AW-1:0]      word_q;
  logic [BITSIZE-1:0] wdata_q;
  logic [BITSIZE-1:0] rdata_q;
  logic               err_q;
  logic [AW-1:0]      chk_word;
  logic               chk_err;

  mem_addr_check #(
    .BITSIZE(BITSIZE),
    .MEMSIZE(MEMSIZE)
  ) u_addr_check (
    .addr(bus.req_addr),
    .word(chk_word),
    .err (chk_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= bus.req_write;
      word_q  <= chk_word;
      wdata_q <= bus.req_wdata;
      err_q   <= chk_err;
      if (chk_err) rdata_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= write_q ? '0 : bus.mem_rdata;
    end
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = chk_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_addr  = word_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = write_q;
        bus.mem_re    = !write_q;
        state_nx      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed self-checking bench for mem_req_master (BITSIZE=64, MEMSIZE=64).
module tb_mem_req_master;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned we_cnt   = 0;
  int unsigned re_cnt   = 0;
  int unsigned both_cnt = 0;
  logic [63:0] mem [64];

  localparam logic [63:0] PAT = 64'hDEADBEEF_CAFEF00D;

  mem_req_master_if #(.BITSIZE(64), .MEMSIZE(64)) bus ();

  mem_req_master #(.BITSIZE(64), .MEMSIZE(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_we) we_cnt++;
    if (bus.mem_re) re_cnt++;
    if (bus.mem_we && bus.mem_re) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err",   bus.rsp_err, 0);
    check("rst_mem_we",    bus.mem_we, 0);
    check("rst_mem_re",    bus.mem_re, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // store PAT @0x40 then load it back
    drive(1'b1, 64'h40, PAT);
    check("st_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("st_acc_we",    bus.mem_we, 1);
    check("st_acc_re",    bus.mem_re, 0);
    check("st_acc_addr",  bus.mem_addr, 8);
    check("st_acc_wdata", bus.mem_wdata, PAT);
    check("st_acc_rdy",   bus.req_ready, 0);
    check("st_acc_rspv",  bus.rsp_valid, 0);
    tick();
    check("st_rsp_valid", bus.rsp_valid, 1);
    check("st_rsp_err",   bus.rsp_err, 0);
    check("st_rsp_rdata", bus.rsp_rdata, 0);
    check("st_rsp_we",    bus.mem_we, 0);
    tick();
    check("st_idle_rdy",  bus.req_ready, 1);
    check("st_we_cnt",    we_cnt, 1);

    drive(1'b0, 64'h40, '0);
    tick();
    bus.req_valid = 1'b0;
    check("ld_acc_re",    bus.mem_re, 1);
    check("ld_acc_we",    bus.mem_we, 0);
    check("ld_acc_addr",  bus.mem_addr, 8);
    tick();
    check("ld_rsp_valid", bus.rsp_valid, 1);
    check("ld_rsp_rdata", bus.rsp_rdata, PAT);
    check("ld_rsp_err",   bus.rsp_err, 0);
    tick();

    // response back-pressure; a second request must be ignored
    bus.rsp_ready = 1'b0;
    drive(1'b0, 64'h40, '0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    drive(1'b1, 64'h50, '1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_rdata", bus.rsp_rdata, PAT);
      check("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check("bp_hold_valid", bus.rsp_valid, 1);
    tick();
    check("bp_done_valid", bus.rsp_valid, 0);
    check("bp_done_ready", bus.req_ready, 1);
    check("bp_no_store",   mem[10], 0);
    check("bp_we_cnt",     we_cnt, 1);

    // reserved word and out-of-range word
    drive(1'b1, 64'h1F8, '1);
    tick();
    bus.req_valid = 1'b0;
    check("rsv_valid", bus.rsp_valid, 1);
    check("rsv_err",   bus.rsp_err, 1);
    check("rsv_rdata", bus.rsp_rdata, 0);
    check("rsv_we",    bus.mem_we, 0);
    tick();
    drive(1'b0, 64'h200, '0);
    tick();
    bus.req_valid = 1'b0;
    check("oor_valid", bus.rsp_valid, 1);
    check("oor_err",   bus.rsp_err, 1);
    check("oor_rdata", bus.rsp_rdata, 0);
    check("oor_re",    bus.mem_re, 0);
    tick();
    check("err_we_cnt", we_cnt, 1);
    check("err_re_cnt", re_cnt, 2);
    check("rsv_mem63",  mem[63], 0);

    // misaligned load @0x43
    drive(1'b0, 64'h43, '0);
    tick();
    bus.req_valid = 1'b0;
`ifdef MEM_REQ_MISALIGN_TRAP_EN
    check("mis_valid", bus.rsp_valid, 1);
    check("mis_err",   bus.rsp_err, 1);
    check("mis_re",    bus.mem_re, 0);
    check("mis_rdata", bus.rsp_rdata, 0);
    tick();
`else
    check("mis_re",    bus.mem_re, 1);
    check("mis_addr",  bus.mem_addr, 8);
    tick();
    check("mis_rdata", bus.rsp_rdata, PAT);
    check("mis_err",   bus.rsp_err, 0);
    tick();
`endif

    // reset during the ACCESS cycle of a store @0x48
    drive(1'b1, 64'h48, 64'h1234);
    tick();
    bus.req_valid = 1'b0;
    check("ra_we",   bus.mem_we, 1);
    check("ra_addr", bus.mem_addr, 9);
    #2 rst = 1'b0;
    #1;
    check("ra_rst_we",    bus.mem_we, 0);
    check("ra_rst_re",    bus.mem_re, 0);
    check("ra_rst_valid", bus.rsp_valid, 0);
    check("ra_rst_ready", bus.req_ready, 1);
    check("ra_rst_addr",  bus.mem_addr, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    drive(1'b0, 64'h48, '0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("ra_ld_valid", bus.rsp_valid, 1);
    check("ra_ld_rdata", bus.rsp_rdata, 0);
    check("ra_ld_err",   bus.rsp_err, 0);
    tick();
    check("ra_mem9",   mem[9], 0);
    check("both_cnt",  both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
